// File: rtl/hier_path_pkg.sv
// ============================================================================
// Module   : hier_path_pkg
// Brief    : Shared types and default constants for the hierarchical path
//            decoder (FSM state, default tree shape, result record).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hier_path_pkg;

    localparam int HP_DEPTH   = 10;
    localparam int HP_FANOUT  = 5;
    localparam int HP_IDX_W   = 24;
    localparam int HP_DEPTH_W = $clog2(HP_DEPTH + 1);

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DRAIN  = 2'd1,
        OUTPUT = 2'd2
    } hp_state_t;

    typedef struct packed {
        logic [HP_IDX_W-1:0]   index;
        logic [HP_DEPTH_W-1:0] depth;
        logic                  error;
    } hp_result_t;

endpackage

`default_nettype wire

// File: rtl/hier_path_stats.sv
// ============================================================================
// Module   : hier_path_stats
// Brief    : Pair of 16-bit saturating event counters (paths, error paths).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hier_path_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc_path,
    input  logic        i_inc_error,
    output logic [15:0] o_stat_paths,
    output logic [15:0] o_stat_errors
);

    localparam logic [15:0] c_sat = 16'hFFFF;

    logic [15:0] r_paths;
    logic [15:0] r_errors;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_paths  <= '0;
            r_errors <= '0;
        end else begin
            if (i_inc_path && (r_paths != c_sat)) begin
                r_paths <= r_paths + 16'd1;
            end
            if (i_inc_error && (r_errors != c_sat)) begin
                r_errors <= r_errors + 16'd1;
            end
        end
    end

    assign o_stat_paths  = r_paths;
    assign o_stat_errors = r_errors;

endmodule

`default_nettype wire

// File: rtl/hier_path_decoder.sv
// ============================================================================
// Module   : hier_path_decoder
// Brief    : Converts a root-first stream of child-select digits into a
//            flattened mixed-radix leaf index, depth and error flag.
//            Optional counters: define HIER_PATH_DECODER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hier_path_decoder
    import hier_path_pkg::*;
#(
    parameter int DEPTH   = HP_DEPTH,
    parameter int FANOUT  = HP_FANOUT,
    parameter int DIGIT_W = 3,
    parameter int IDX_W   = HP_IDX_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DIGIT_W-1:0]           s_digit,
    input  logic                         s_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [IDX_W-1:0]             m_index,
    output logic [$clog2(DEPTH+1)-1:0]   m_depth,
    output logic                         m_error
`ifdef HIER_PATH_DECODER_STATS_EN
    ,
    output logic [15:0]                  stat_paths,
    output logic [15:0]                  stat_errors
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0]   c_depth    = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0]   c_fanout   = IDX_W'(FANOUT);
    localparam logic [DIGIT_W:0]   c_fanout_d = (DIGIT_W + 1)'(FANOUT);

    hp_state_t          r_state;
    hp_state_t          w_state_nxt;
    logic [IDX_W-1:0]   r_acc;
    logic [IDX_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic               r_ready;

    logic               w_beat;
    logic               w_xfer;
    logic               w_digit_bad;
    logic               w_full;
    logic [IDX_W-1:0]   w_digit_ext;
    logic [IDX_W-1:0]   w_mac;

    assign w_beat      = s_valid && r_ready;
    assign w_xfer      = m_valid && m_ready;
    assign w_digit_bad = ({1'b0, s_digit} >= c_fanout_d);
    assign w_full      = (r_count == c_depth);
    // Illegal digits still occupy a level but contribute nothing to the index.
    assign w_digit_ext = w_digit_bad ? '0 : IDX_W'(s_digit);
    assign w_mac       = (r_acc * c_fanout) + w_digit_ext;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        w_err_nxt   = r_err;

        case (r_state)
            ACCUM: begin
                if (w_beat) begin
                    if (w_digit_bad) begin
                        w_err_nxt = 1'b1;
                    end
                    if (w_full) begin
                        w_err_nxt = 1'b1;
                        if (!s_last) begin
                            w_state_nxt = DRAIN;
                        end
                    end else begin
                        w_acc_nxt   = w_mac;
                        w_count_nxt = r_count + CNT_W'(1);
                    end
                    if (s_last) begin
                        w_state_nxt = OUTPUT;
                    end
                end
            end

            DRAIN: begin
                if (w_beat && s_last) begin
                    w_state_nxt = OUTPUT;
                end
            end

            OUTPUT: begin
                if (w_xfer) begin
                    w_acc_nxt   = '0;
                    w_count_nxt = '0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ACCUM;
                end
            end

            default: begin
                w_state_nxt = ACCUM;
            end
        endcase
    end

    // Ready is registered from the next state, so it drops on entry to
    // OUTPUT and rises only the cycle after the result transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_count <= w_count_nxt;
            r_err   <= w_err_nxt;
            r_ready <= (w_state_nxt != OUTPUT);
        end
    end

    assign s_ready = r_ready;
    assign m_valid = (r_state == OUTPUT);
    assign m_index = (m_valid && !r_err) ? r_acc : '0;
    assign m_depth = m_valid ? r_count : '0;
    assign m_error = m_valid && r_err;

`ifdef HIER_PATH_DECODER_STATS_EN
    hier_path_stats u_stats (
        .clk           (clk),
        .rst           (rst),
        .i_inc_path    (w_xfer),
        .i_inc_error   (w_xfer && m_error),
        .o_stat_paths  (stat_paths),
        .o_stat_errors (stat_errors)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_hier_path_decoder.sv
// ============================================================================
// Module   : tb_hier_path_decoder
// Brief    : Self-checking bench for hier_path_decoder (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hier_path_decoder;

    localparam int DEPTH   = 10;
    localparam int FANOUT  = 5;
    localparam int DIGIT_W = 3;
    localparam int IDX_W   = 24;
    localparam int DW      = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               s_valid;
    logic               s_ready;
    logic [DIGIT_W-1:0] s_digit;
    logic               s_last;
    logic               m_valid;
    logic               m_ready;
    logic [IDX_W-1:0]   m_index;
    logic [DW-1:0]      m_depth;
    logic               m_error;
`ifdef HIER_PATH_DECODER_STATS_EN
    logic [15:0]        stat_paths;
    logic [15:0]        stat_errors;
`endif

    always #5 clk = ~clk;

    hier_path_decoder #(
        .DEPTH   (DEPTH),
        .FANOUT  (FANOUT),
        .DIGIT_W (DIGIT_W),
        .IDX_W   (IDX_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_digit (s_digit),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_index (m_index),
        .m_depth (m_depth),
        .m_error (m_error)
`ifdef HIER_PATH_DECODER_STATS_EN
        ,
        .stat_paths  (stat_paths),
        .stat_errors (stat_errors)
`endif
    );

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [DW-1:0]    dep;
        logic             err;
    } res_t;

    res_t res_q[$];
    res_t exp_q[$];
    res_t mon_r;
    int   path_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   exp_paths = 0;
    int   exp_errs  = 0;

    // Capture every result transfer (sampled mid-cycle, transfers on next edge).
    always @(negedge clk) begin
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            mon_r.idx = m_index;
            mon_r.dep = m_depth;
            mon_r.err = m_error;
            res_q.push_back(mon_r);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: leaf index is the base-FANOUT number formed by the first
    // DEPTH digits; any illegal digit or an over-long path marks an error.
    function automatic void model_push();
        res_t   r;
        longint acc  = 0;
        int     n    = path_q.size();
        int     kept = (n > DEPTH) ? DEPTH : n;
        bit     err  = (n > DEPTH);
        for (int i = 0; i < n; i++) begin
            if (path_q[i] >= FANOUT) err = 1'b1;
        end
        for (int i = 0; i < kept; i++) begin
            acc = acc * FANOUT + ((path_q[i] >= FANOUT) ? 0 : path_q[i]);
        end
        r.idx = err ? '0 : acc[IDX_W-1:0];
        r.dep = DW'(kept);
        r.err = err;
        exp_q.push_back(r);
        exp_paths++;
        if (err) exp_errs++;
    endfunction

    task automatic wait_accept();
        int g = 0;
        while (s_ready !== 1'b1 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 100) check("ready_timeout", {31'd0, s_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic send_path();
        int d;
        for (int i = 0; i < path_q.size(); i++) begin
            d       = path_q[i];
            s_valid = 1'b1;
            s_digit = DIGIT_W'(d);
            s_last  = (i == path_q.size() - 1);
            wait_accept();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("latency_m_valid", {31'd0, m_valid}, 32'd1);
        model_push();
    endtask

    task automatic check_next();
        res_t r;
        res_t e;
        int   g = 0;
        while (res_q.size() == 0 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (res_q.size() == 0) begin
            check("result_timeout", res_q.size(), 32'd1);
        end else begin
            r = res_q.pop_front();
            e = exp_q.pop_front();
            check("m_index", r.idx, e.idx);
            check("m_depth", r.dep, e.dep);
            check("m_error", r.err, e.err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int d;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_digit = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;

        // Reset state
        @(posedge clk); #1;
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_index", m_index, 32'd0);
        check("rst_m_depth", m_depth, 32'd0);
        check("rst_m_error", {31'd0, m_error}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

        // Full-depth legal path (259)
        path_q = '{0, 0, 0, 0, 0, 0, 2, 0, 1, 4};
        send_path();
        check("idx259_direct", m_index, 32'd259);
        check_next();

        // Out-of-range digit
        path_q = '{2, 5, 1};
        send_path();
        check_next();

        // Back-to-back: 3,1 then single digit 4
        path_q = '{3, 1};
        send_path();
        path_q = '{4};
        send_path();
        check_next();
        check_next();

        // Overflow with drain
        path_q = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        send_path();
        check_next();

        // Back-pressure during OUTPUT; pending digit must stall, not drop
        m_ready = 1'b0;
        path_q  = '{3, 1};
        send_path();
        s_valid = 1'b1;
        s_digit = 3'd2;
        s_last  = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("hold_m_valid", {31'd0, m_valid}, 32'd1);
            check("hold_m_index", m_index, exp_q[0].idx);
            check("hold_m_depth", m_depth, exp_q[0].dep);
            check("hold_s_ready", {31'd0, s_ready}, 32'd0);
        end
        m_ready = 1'b1;
        wait_accept();
        s_valid = 1'b0;
        s_last  = 1'b0;
        path_q  = '{2};
        model_push();
        check_next();
        check_next();

        // Reset mid-path discards the partial path
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_digit = 3'(i + 1);
            s_last  = 1'b0;
            wait_accept();
        end
        s_valid = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
        check("midrst_s_ready", {31'd0, s_ready}, 32'd0);
        check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_no_result", res_q.size(), 32'd0);
`ifdef HIER_PATH_DECODER_STATS_EN
        check("midrst_stat_paths", stat_paths, 32'd0);
        exp_paths = 0;
        exp_errs  = 0;
`endif
        path_q = '{1, 1};
        send_path();
        check_next();

        // Randomized paths with occasional back-pressure and overlong paths
        for (int p = 0; p < 30; p++) begin
            len = $urandom_range(1, 13);
            path_q.delete();
            for (int i = 0; i < len; i++) begin
                d = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
                path_q.push_back(d);
            end
            m_ready = ($urandom_range(0, 3) != 0);
            send_path();
            if (!m_ready) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                end
                check("rand_hold_m_valid", {31'd0, m_valid}, 32'd1);
                m_ready = 1'b1;
            end
            check_next();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

`ifdef HIER_PATH_DECODER_STATS_EN
        @(posedge clk); #1;
        check("stat_paths", stat_paths, exp_paths);
        check("stat_errors", stat_errors, exp_errs);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
